// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: column drive, row debounce, key-code mapping and a
// valid/ack handshake with sticky overrun when a key arrives before the last one is consumed.
module keypad_scan_ctrl #(
  parameter int unsigned clk_freq      = 125_000_000,
  parameter int unsigned stable_time   = 10,
  parameter int unsigned settle_cycles = 125
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_held,
  output logic       overrun
);

  localparam int unsigned STABLE_RAW = clk_freq / 1000 * stable_time;
  localparam int unsigned STABLE_CYC = (STABLE_RAW < 1) ? 1 : STABLE_RAW;
  localparam int unsigned SETTLE_CYC = (settle_cycles < 1) ? 1 : settle_cycles;
  localparam int unsigned CNT_MAX    = (STABLE_CYC > SETTLE_CYC) ? STABLE_CYC : SETTLE_CYC;
  localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);

  localparam logic [1:0] S_SCAN     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_HELD     = 2'd2;
  localparam logic [1:0] S_RELEASE  = 2'd3;

  logic [3:0]       sync1_q, sync2_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       c_q, c_d;
  logic [3:0]       pat_q, pat_d;
  logic [1:0]       rsel_q, rsel_d;
  logic             held_q, held_d;
  logic [3:0]       key_code_q;
  logic             key_valid_q;
  logic             overrun_q;

  logic             accept;
  logic             rows_high;
  logic [1:0]       low_row;
  logic             low_found;
  logic [3:0]       mapped_code;

  function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    k = '0;
    case ({r, c})
      4'b00_00: k = 4'h1;
      4'b00_01: k = 4'h2;
      4'b00_10: k = 4'h3;
      4'b00_11: k = 4'hA;
      4'b01_00: k = 4'h4;
      4'b01_01: k = 4'h5;
      4'b01_10: k = 4'h6;
      4'b01_11: k = 4'hB;
      4'b10_00: k = 4'h7;
      4'b10_01: k = 4'h8;
      4'b10_10: k = 4'h9;
      4'b10_11: k = 4'hC;
      4'b11_00: k = 4'h0;
      4'b11_01: k = 4'hF;
      4'b11_10: k = 4'hE;
      4'b11_11: k = 4'hD;
      default:  k = '0;
    endcase
    return k;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= row;
      sync2_q <= sync1_q;
    end
  end

  assign rows_high = &sync2_q;

  always_comb begin
    low_row   = '0;
    low_found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!sync2_q[i] && !low_found) begin
        low_row   = 2'(i);
        low_found = 1'b1;
      end
    end
  end

  // Counter is shared by settle, debounce and release timing; it is cleared on every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    pat_d   = pat_q;
    rsel_d  = rsel_q;
    held_d  = held_q;
    accept  = 1'b0;
    case (state_q)
      S_SCAN: begin
        if (cnt_q != SETTLE_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else if (rows_high) begin
          cnt_d = '0;
          c_d   = c_q + 2'd1;
        end else begin
          cnt_d   = '0;
          pat_d   = sync2_q;
          rsel_d  = low_row;
          state_d = S_DEBOUNCE;
        end
      end
      S_DEBOUNCE: begin
        if (sync2_q != pat_q) begin
          cnt_d   = '0;
          state_d = S_SCAN;
        end else if (cnt_q == STABLE_LAST) begin
          cnt_d   = '0;
          accept  = 1'b1;
          held_d  = 1'b1;
          state_d = S_HELD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HELD: begin
        cnt_d = '0;
        if (rows_high) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!rows_high) begin
          cnt_d   = '0;
          state_d = S_HELD;
        end else if (cnt_q == STABLE_LAST) begin
          cnt_d   = '0;
          held_d  = 1'b0;
          c_d     = c_q + 2'd1;
          state_d = S_SCAN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_SCAN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_SCAN;
      cnt_q   <= '0;
      c_q     <= '0;
      pat_q   <= '1;
      rsel_q  <= '0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      pat_q   <= pat_d;
      rsel_q  <= rsel_d;
      held_q  <= held_d;
    end
  end

  assign mapped_code = map_key(rsel_q, c_q);

  // An ack landing in the accept cycle frees the slot, so the new key loads instead of overrunning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (accept) begin
        if (!key_valid_q || key_ack) begin
          key_code_q  <= mapped_code;
          key_valid_q <= 1'b1;
        end
      end else if (key_valid_q && key_ack) begin
        key_valid_q <= 1'b0;
      end

      if (accept && key_valid_q && !key_ack) begin
        overrun_q <= 1'b1;
      end else if (key_valid_q && key_ack) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign col       = ~(4'b0001 << c_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = held_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a physical keypad model drives rows from the column drive,
// and an event-level handshake model predicts key_valid/key_code/overrun.
module tb_keypad_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       key_held;
  logic       overrun;

  logic       pressed;
  logic [1:0] pr, pc;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;

  logic       exp_valid;
  logic [3:0] exp_code;
  logic       exp_over;

  logic [3:0] km [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                          4'h4, 4'h5, 4'h6, 4'hB,
                          4'h7, 4'h8, 4'h9, 4'hC,
                          4'h0, 4'hF, 4'hE, 4'hD};

  keypad_scan_ctrl #(
    .clk_freq      (1000),
    .stable_time   (4),
    .settle_cycles (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .key_held  (key_held),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // A pressed key shorts its row to its column, so the row reads low only while that column is driven.
  always_comb begin
    row = 4'hF;
    if (pressed && !col[pc]) row[pr] = 1'b0;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int col_idx(input logic [3:0] v);
    logic [3:0] onehot;
    col_idx = 4;
    for (int i = 0; i < 4; i++) begin
      onehot = 4'b0001 << i;
      if (v == ~onehot) col_idx = i;
    end
  endfunction

  function automatic logic [3:0] col_of(input int unsigned c);
    logic [3:0] v;
    v = 4'b0001 << (c % 4);
    return ~v;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_valid"}, key_valid, exp_valid);
    check({tag, "_code"}, key_code, exp_code);
    check({tag, "_overrun"}, overrun, exp_over);
  endtask

  task automatic model_reset();
    exp_valid = 1'b0;
    exp_code  = 4'h0;
    exp_over  = 1'b0;
  endtask

  task automatic model_accept(input logic [3:0] code, input bit ack_now);
    if (ack_now && exp_valid) exp_over = 1'b0;
    if (!exp_valid || ack_now) begin
      exp_valid = 1'b1;
      exp_code  = code;
    end else begin
      exp_over = 1'b1;
    end
  endtask

  // Idle scanning after reset release: column k changes every settle+1 = 3 clocks.
  task automatic scan_idle(input int unsigned n);
    for (int unsigned i = 1; i <= n; i++) begin
      step();
      check("scan_col", col, col_of(i / 3));
      check("scan_no_valid", key_valid, 1'b0);
    end
  endtask

  task automatic arm_key(input int unsigned r, input int unsigned c);
    int unsigned n;
    n = 0;
    while (col_idx(col) == int'(c) && n < 50) begin step(); n++; end
    pr = 2'(r);
    pc = 2'(c);
    pressed = 1'b1;
    n = 0;
    while (row == 4'hF && n < 50) begin step(); n++; end
    check("press_row_low", row != 4'hF, 1'b1);
  endtask

  task automatic press_key(input int unsigned r, input int unsigned c, input bit ack_now);
    int unsigned n, t0, lat;
    arm_key(r, c);
    t0 = cyc;
    if (ack_now) begin
      repeat (6) @(posedge clk);
      #1;
      key_ack = 1'b1;
      step();
      key_ack = 1'b0;
    end else begin
      n = 0;
      while (!key_held && n < 40) begin step(); n++; end
    end
    lat = cyc - t0;
    check("accept_latency", (lat >= 6 && lat <= 8) ? 7 : lat, 7);
    check("key_held_on", key_held, 1'b1);
    model_accept(km[r*4 + c], ack_now);
    check_outputs("accept");
  endtask

  task automatic release_key(input int unsigned c);
    int unsigned n, t0, lat;
    pressed = 1'b0;
    t0 = cyc;
    n = 0;
    while (key_held && n < 40) begin step(); n++; end
    lat = cyc - t0;
    check("release_latency", (lat >= 6 && lat <= 8) ? 7 : lat, 7);
    check("key_held_off", key_held, 1'b0);
    check("scan_next_col", col, col_of(c + 1));
    check_outputs("release");
  endtask

  task automatic ack_pulse();
    key_ack = 1'b1;
    step();
    key_ack = 1'b0;
    if (exp_valid) begin
      exp_valid = 1'b0;
      exp_over  = 1'b0;
    end
    check_outputs("ack");
  endtask

  initial begin
    rst_n   = 1'b0;
    key_ack = 1'b0;
    pressed = 1'b0;
    pr      = '0;
    pc      = '0;
    model_reset();
    #3;
    check("rst_col", col, 4'b1110);
    check("rst_held", key_held, 1'b0);
    check_outputs("rst");
    repeat (3) step();
    rst_n = 1'b1;

    scan_idle(40);

    press_key(1, 2, 1'b0);
    check("key6_code", key_code, 4'h6);
    release_key(2);
    ack_pulse();

    arm_key(0, 0);
    repeat (2) step();
    pressed = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      step();
      check("bounce_col", col, 4'b1110);
      check("bounce_held", key_held, 1'b0);
    end
    for (int unsigned i = 0; i < 20; i++) begin
      step();
      check("bounce_no_valid", key_valid, 1'b0);
    end

    press_key(0, 0, 1'b0);
    release_key(0);
    press_key(3, 3, 1'b0);
    release_key(3);
    check("overrun_code_kept", key_code, 4'h1);
    ack_pulse();

    press_key(0, 0, 1'b0);
    release_key(0);
    press_key(0, 1, 1'b0);
    release_key(1);
    press_key(3, 0, 1'b1);
    check("ack_same_cycle_code", key_code, 4'h0);
    release_key(0);
    ack_pulse();
    ack_pulse();

    for (int unsigned k = 0; k < 12; k++) begin
      int unsigned r, c;
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      press_key(r, c, 1'b0);
      release_key(c);
      if ($urandom_range(0, 1) == 1) ack_pulse();
    end

    if (exp_valid) ack_pulse();
    press_key(1, 1, 1'b0);
    release_key(1);
    arm_key(2, 2);
    repeat (4) step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_col", col, 4'b1110);
    check("arst_held", key_held, 1'b0);
    check_outputs("arst");
    pressed = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    check("post_rst_col", col, 4'b1110);
    scan_idle(30);
    check_outputs("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
